operand_fetch_stage: RTL

- Decode/operand-fetch pipeline stage sitting directly upstream of the register file and execute stage.
- Drives the register-file read addresses Rsrc1/Rsrc2 and captures RA/RB into the RA/RB pipeline registers for execute.
- Tracks in-flight destination writes with a pending-write scoreboard and stalls issue on RAW/WAW hazards.
- Consumes the writeback bus (Rdst, RY, RF_WRITE) that also feeds the register file, using it to clear the scoreboard and optionally bypass.

---
 rtl/ofs_pkg.sv | 18 +
 rtl/ofs_scoreboard.sv | 54 +++++
 rtl/operand_fetch_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ofs_pkg.sv
// Shared defaults and types for the operand fetch stage.
// The optional writeback bypass is enabled with the OFS_WB_BYPASS_EN macro.
package ofs_pkg;

   localparam int DEFAULT_DATA_W   = 32;
   localparam int DEFAULT_ADDR_W   = 5;
   localparam int DEFAULT_NUM_REGS = 32;

   // One instruction's worth of state held in the RA/RB pipeline registers.
   // Field widths are fixed to the package defaults.
   typedef struct packed {
      logic [DEFAULT_DATA_W-1:0] ra;
      logic [DEFAULT_DATA_W-1:0] rb;
      logic [DEFAULT_ADDR_W-1:0] rdst;
      logic                      wr;
   } ex_rec_t;

endpackage

// File: rtl/ofs_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when an instruction
// that writes the register issues, cleared when the writeback arrives.
// Reads are combinational.
module ofs_scoreboard
   import ofs_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_en,
   input  logic [ADDR_W-1:0]   set_addr,
   input  logic                clr_en,
   input  logic [ADDR_W-1:0]   clr_addr,
   input  logic [ADDR_W-1:0]   rd_addr1,
   input  logic [ADDR_W-1:0]   rd_addr2,
   input  logic [ADDR_W-1:0]   rd_addr_dst,
   output logic                rd_pend1,
   output logic                rd_pend2,
   output logic                rd_pend_dst,
   output logic [NUM_REGS-1:0] pending
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Clear first, then set, so a new writer to the register being written
   // back in the same cycle keeps its bit.
   always_comb begin
      pending_d = pending_q;
      if (clr_en) begin
         pending_d[clr_addr] = 1'b0;
      end
      if (set_en) begin
         pending_d[set_addr] = 1'b1;
      end
   end

   // Bitmap register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign rd_pend1    = pending_q[rd_addr1];
   assign rd_pend2    = pending_q[rd_addr2];
   assign rd_pend_dst = pending_q[rd_addr_dst];
   assign pending     = pending_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register file read addresses, captures RA/RB
// into the execute pipeline registers, and stalls on RAW/WAW hazards
// tracked by a pending-write scoreboard.
// Define OFS_WB_BYPASS_EN to let a RAW source take the same-cycle
// writeback data instead of waiting a cycle for the register file.
module operand_fetch_stage
   import ofs_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ADDR_W-1:0]   id_rsrc1,
   input  logic [ADDR_W-1:0]   id_rsrc2,
   input  logic [ADDR_W-1:0]   id_rdst,
   input  logic                id_use1,
   input  logic                id_use2,
   input  logic                id_wr,
   output logic [ADDR_W-1:0]   rf_rsrc1,
   output logic [ADDR_W-1:0]   rf_rsrc2,
   input  logic [DATA_W-1:0]   rf_ra,
   input  logic [DATA_W-1:0]   rf_rb,
   input  logic                wb_rf_write,
   input  logic [ADDR_W-1:0]   wb_rdst,
   input  logic [DATA_W-1:0]   wb_ry,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [DATA_W-1:0]   ex_ra,
   output logic [DATA_W-1:0]   ex_rb,
   output logic [ADDR_W-1:0]   ex_rdst,
   output logic                ex_wr,
   output logic [NUM_REGS-1:0] pending
);

`ifdef OFS_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic    ex_valid_q;
   ex_rec_t ex_q;

   logic pend1;
   logic pend2;
   logic pend_dst;
   logic slot_free;
   logic byp1;
   logic byp2;
   logic bypw;
   logic raw1;
   logic raw2;
   logic waw;
   logic issue;

   assign rf_rsrc1 = id_rsrc1;
   assign rf_rsrc2 = id_rsrc2;

   ofs_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_en      (issue & id_wr),
      .set_addr    (id_rdst),
      .clr_en      (wb_rf_write),
      .clr_addr    (wb_rdst),
      .rd_addr1    (id_rsrc1),
      .rd_addr2    (id_rsrc2),
      .rd_addr_dst (id_rdst),
      .rd_pend1    (pend1),
      .rd_pend2    (pend2),
      .rd_pend_dst (pend_dst),
      .pending     (pending)
   );

   // Hazard detection and issue decision. A destination match against the
   // writeback in flight always clears WAW, since the bit is being released
   // this edge; sources only escape RAW when bypass is built in.
   always_comb begin
      slot_free = !ex_valid_q | ex_ready;
      byp1      = wb_rf_write & (wb_rdst == id_rsrc1);
      byp2      = wb_rf_write & (wb_rdst == id_rsrc2);
      bypw      = wb_rf_write & (wb_rdst == id_rdst);
      raw1      = id_use1 & pend1 & !(BYP & byp1);
      raw2      = id_use2 & pend2 & !(BYP & byp2);
      waw       = id_wr & pend_dst & !bypw;
      id_ready  = slot_free & !raw1 & !raw2 & !waw;
      issue     = id_valid & id_ready;
   end

   // RA/RB pipeline registers: load on issue, drain when execute consumes,
   // otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (issue) begin
         ex_valid_q <= 1'b1;
         ex_q.ra    <= (BYP & byp1) ? wb_ry : rf_ra;
         ex_q.rb    <= (BYP & byp2) ? wb_ry : rf_rb;
         ex_q.rdst  <= id_rdst;
         ex_q.wr    <= id_wr;
      end else if (ex_ready && ex_valid_q) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_ra    = ex_q.ra;
   assign ex_rb    = ex_q.rb;
   assign ex_rdst  = ex_q.rdst;
   assign ex_wr    = ex_q.wr;

endmodule
